pipe_shifter: RTL and testbench

- Parametrised, fully pipelined barrel shifter; next generation of the combinational 32-bit right shifter.
- Width is generic. Supports logical right, arithmetic right and logical left shifts, plus rotate right when the optional feature is compiled in.
- One registered stage per shift-amount bit; valid/ready handshake at both ends; global stall on backpressure.
- Sits between ALU operand select and the result mux in the execute path.

---
 rtl/shift_pkg.sv | 14 +
 rtl/pipe_shift_stage.sv | 84 ++++++++
 rtl/pipe_shifter.sv | 77 +++++++
 tb/tb_pipe_shifter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types for the pipelined barrel shifter.
// Contents: shift_op_t opcode encoding and its width.
package shift_pkg;

    localparam int unsigned SHIFT_OP_W = 2;

    typedef enum logic [SHIFT_OP_W-1:0] {
        SH_SRL = 2'b00,
        SH_SRA = 2'b01,
        SH_SLL = 2'b10,
        SH_ROR = 2'b11
    } shift_op_t;

endpackage

// File: rtl/pipe_shift_stage.sv
// One registered stage of the pipelined barrel shifter: shifts by DIST when
// shamt bit log2(DIST) is set, then registers the result with its sideband.
// Optional feature: PIPE_SHIFTER_ROTATE_EN enables rotate-right for SH_ROR;
// without it SH_ROR shifts exactly like SH_SRL.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   en_i             advance enable (low = hold everything)
//   valid_i/valid_o  beat valid in / registered out
//   data_i/data_o    data in / registered shifted data out
//   shamt_i/shamt_o  full shift amount, carried down the pipe
//   op_i/op_o        shift operation, carried down the pipe
//   fill_i/fill_o    original operand MSB for arithmetic fill
module pipe_shift_stage
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH),
    parameter int unsigned DIST  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [SHW-1:0]   shamt_i,
    input  shift_op_t        op_i,
    input  logic             fill_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [SHW-1:0]   shamt_o,
    output shift_op_t        op_o,
    output logic             fill_o
);

    localparam int unsigned K = $clog2(DIST);

    logic             valid_q;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;
    logic [SHW-1:0]   shamt_q;
    shift_op_t        op_q;
    logic             fill_q;

    // Shift by DIST with op-specific fill, or pass through.
    always_comb begin
        data_d = data_i;
        if (shamt_i[K]) begin
            case (op_i)
                SH_SRA:  data_d = {{DIST{fill_i}}, data_i[WIDTH-1:DIST]};
                SH_SLL:  data_d = {data_i[WIDTH-1-DIST:0], {DIST{1'b0}}};
`ifdef PIPE_SHIFTER_ROTATE_EN
                SH_ROR:  data_d = {data_i[DIST-1:0], data_i[WIDTH-1:DIST]};
`endif
                default: data_d = {{DIST{1'b0}}, data_i[WIDTH-1:DIST]};
            endcase
        end
    end

    // Payload only loads with a real beat so bubbles leave the data quiet.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            shamt_q <= '0;
            op_q    <= SH_SRL;
            fill_q  <= 1'b0;
        end else if (en_i) begin
            valid_q <= valid_i;
            if (valid_i) begin
                data_q  <= data_d;
                shamt_q <= shamt_i;
                op_q    <= op_i;
                fill_q  <= fill_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign shamt_o = shamt_q;
    assign op_o    = op_q;
    assign fill_o  = fill_q;

endmodule

// File: rtl/pipe_shifter.sv
// Fully pipelined barrel shifter: SHW registered stages, stage k shifting by
// 2^k. Valid/ready at both ends with a global stall on output backpressure.
// Latency SHW cycles, throughput one beat per cycle, strictly in order.
// Optional feature: PIPE_SHIFTER_ROTATE_EN (rotate right on SH_ROR).
// Parameters: WIDTH (power of 2, >= 2); SHW is derived, do not override.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   in_valid   input beat valid         in_ready  can accept (combinational)
//   in_data    operand                  in_shamt  shift amount 0..WIDTH-1
//   in_op      shift_op_t
//   out_valid  result valid             out_ready consumer accepts
//   out_data   shifted result
module pipe_shifter
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  shift_op_t        in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             valid_s [SHW+1];
    logic [WIDTH-1:0] data_s  [SHW+1];
    logic [SHW-1:0]   shamt_s [SHW+1];
    shift_op_t        op_s    [SHW+1];
    logic             fill_s  [SHW+1];
    logic             stall;
    logic             unused_tail;

    // Whole pipe freezes while the output beat is refused.
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    assign valid_s[0] = in_valid & in_ready;
    assign data_s[0]  = in_data;
    assign shamt_s[0] = in_shamt;
    assign op_s[0]    = in_op;
    assign fill_s[0]  = in_data[WIDTH-1];

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        pipe_shift_stage #(
            .WIDTH (WIDTH),
            .SHW   (SHW),
            .DIST  (2 ** k)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en_i    (~stall),
            .valid_i (valid_s[k]),
            .data_i  (data_s[k]),
            .shamt_i (shamt_s[k]),
            .op_i    (op_s[k]),
            .fill_i  (fill_s[k]),
            .valid_o (valid_s[k+1]),
            .data_o  (data_s[k+1]),
            .shamt_o (shamt_s[k+1]),
            .op_o    (op_s[k+1]),
            .fill_o  (fill_s[k+1])
        );
    end

    assign out_valid = valid_s[SHW];
    assign out_data  = data_s[SHW];

    // Sideband leaving the last stage has no consumer.
    assign unused_tail = ^{shamt_s[SHW], op_s[SHW], fill_s[SHW]};

endmodule

// File: tb/tb_pipe_shifter.sv
// Directed and randomised checks of pipe_shifter at WIDTH=32.
module tb_pipe_shifter;
    import shift_pkg::*;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned SHW   = 5;
    localparam int unsigned NRAND = 10000;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shamt;
    shift_op_t        in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    int n_assert = 0;
    int n_fail   = 0;

    pipe_shifter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] s,
                                          input shift_op_t op);
        logic [31:0] r;
        case (op)
            SH_SRA:  r = 32'($signed(d) >>> s);
            SH_SLL:  r = d << s;
`ifdef PIPE_SHIFTER_ROTATE_EN
            SH_ROR:  r = (d >> s) | (d << (6'd32 - {1'b0, s}));
`endif
            default: r = d >> s;
        endcase
        return r;
    endfunction

    // Single beat through an empty pipe: checks latency and result.
    task automatic run_one(input string tag, input logic [31:0] d, input logic [4:0] s,
                           input shift_op_t op, input logic [31:0] exp);
        in_valid  = 1'b1;
        in_data   = d;
        in_shamt  = s;
        in_op     = op;
        out_ready = 1'b1;
        #1;
        chk1({tag, " in_ready"}, in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        in_data  = 32'hA5A5_5A5A;
        in_shamt = 5'd7;
        in_op    = SH_SLL;
        for (int i = 1; i < int'(SHW); i++) begin
            chk1({tag, " early"}, out_valid, 1'b0);
            step();
        end
        chk1({tag, " valid"}, out_valid, 1'b1);
        chk({tag, " data"}, out_data, exp);
        step();
        chk1({tag, " gone"}, out_valid, 1'b0);
    endtask

    initial begin
        logic [31:0] bp_exp [8];
        logic [31:0] bp_d   [8];
        logic [31:0] q [$];
        int sent, got, stalls, acc, cyc;

        // Reset held for two cycles with input valid.
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hFFFF_FFFF;
        in_shamt  = 5'd3;
        in_op     = SH_SRA;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk1("rst valid", out_valid, 1'b0);
            chk("rst data", out_data, 32'h0);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk1("post-rst valid", out_valid, 1'b0);
            chk("post-rst data", out_data, 32'h0);
        end

        // Directed single beats.
        run_one("sra neg", 32'h8000_0000, 5'd4, SH_SRA, 32'hF800_0000);
        run_one("srl", 32'h8000_0000, 5'd4, SH_SRL, 32'h0800_0000);
        run_one("sll 31", 32'h0000_000F, 5'd31, SH_SLL, 32'h8000_0000);
`ifdef PIPE_SHIFTER_ROTATE_EN
        run_one("ror 1", 32'h0000_0001, 5'd1, SH_ROR, 32'h8000_0000);
        run_one("ror 8", 32'h1234_5678, 5'd8, SH_ROR, 32'h7812_3456);
`else
        run_one("ror 1", 32'h0000_0001, 5'd1, SH_ROR, 32'h0000_0000);
        run_one("ror 8", 32'h1234_5678, 5'd8, SH_ROR, 32'h0012_3456);
`endif
        run_one("sra pos", 32'h7000_0000, 5'd8, SH_SRA, 32'h0070_0000);
        run_one("sra 31", 32'h8000_0001, 5'd31, SH_SRA, 32'hFFFF_FFFF);
        run_one("sll 4", 32'h1234_5678, 5'd4, SH_SLL, 32'h2345_6780);
        run_one("srl0", 32'hDEAD_BEEF, 5'd0, SH_SRL, 32'hDEAD_BEEF);
        run_one("sra0", 32'hDEAD_BEEF, 5'd0, SH_SRA, 32'hDEAD_BEEF);
        run_one("sll0", 32'hDEAD_BEEF, 5'd0, SH_SLL, 32'hDEAD_BEEF);
        run_one("ror0", 32'hDEAD_BEEF, 5'd0, SH_ROR, 32'hDEAD_BEEF);

        // Eight back-to-back beats, output refused for three cycles.
        for (int i = 0; i < 8; i++) begin
            bp_d[i]   = 32'h8765_4321 ^ (32'(i) * 32'h0101_0101);
            bp_exp[i] = model(bp_d[i], 5'(i * 3 + 1), shift_op_t'(2'(i % 4)));
        end
        sent = 0; got = 0; stalls = 0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            in_valid  = (sent < 8);
            in_data   = bp_d[sent % 8];
            in_shamt  = 5'(sent * 3 + 1);
            in_op     = shift_op_t'(2'(sent % 4));
            out_ready = !(c >= 6 && c <= 8);
            #1;
            if (out_valid && !out_ready) begin
                chk1("bp in_ready", in_ready, 1'b0);
                stalls++;
            end
            if (out_valid) chk("bp data", out_data, bp_exp[got]);
            if (out_valid && out_ready) got++;
            if (in_valid && in_ready) sent++;
            step();
        end
        in_valid = 1'b0;
        chk("bp got", 32'(got), 32'd8);
        chk("bp sent", 32'(sent), 32'd8);
        chk("bp stalls", 32'(stalls), 32'd3);
        chk1("bp no dup", out_valid, 1'b0);

        // Reset while three beats are in flight.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_shamt  = 5'd4;
        in_op     = SH_SRL;
        in_data   = 32'h0000_00F0;
        step();
        in_data = 32'h0000_0F00;
        step();
        rst     = 1'b1;
        in_data = 32'h0000_F000;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk1("flush valid", out_valid, 1'b0);
            chk("flush data", out_data, 32'h0);
            step();
        end
        run_one("post-flush", 32'h0000_00F0, 5'd4, SH_SRL, 32'h0000_000F);

        // Random traffic against the reference model.
        acc = 0; cyc = 0;
        while ((acc < int'(NRAND) || q.size() != 0) && cyc < 60000) begin
            in_valid  = (acc < int'(NRAND)) && ($urandom_range(0, 9) < 7);
            in_data   = $urandom;
            in_shamt  = 5'($urandom_range(0, 31));
            in_op     = shift_op_t'(2'($urandom_range(0, 3)));
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk1("rand extra", out_valid, 1'b0);
                else chk("rand data", out_data, q.pop_front());
            end
            if (in_valid && in_ready) begin
                q.push_back(model(in_data, in_shamt, in_op));
                acc++;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0;
        chk("rand accepted", 32'(acc), NRAND);
        chk("rand left", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
